// File: rtl/adc_chan_averager_if.sv
// DRP request/response and averaged-result stream for adc_chan_averager.
// master: the averager side; slave: the DRP port and the result consumer.
interface adc_chan_averager_if #(
    parameter int unsigned DATA_W = 12,
    parameter int unsigned ADDR_W = 7
);
    logic              den;
    logic [ADDR_W-1:0] daddr;
    logic              drdy;
    logic [15:0]       do_in;
    logic              avg_valid;
    logic              avg_ready;
    logic [2:0]        avg_chan;
    logic [DATA_W-1:0] avg_data;

    modport master (
        output den, daddr, avg_valid, avg_chan, avg_data,
        input  drdy, do_in, avg_ready
    );

    modport slave (
        input  den, daddr, avg_valid, avg_chan, avg_data,
        output drdy, do_in, avg_ready
    );
endinterface

// File: rtl/adc_chan_averager.sv
// Round-robin DRP sampler averaging 2^AVG_LOG2 readings per ADC channel.
// Macro ADC_AVG_DEADBAND_EN adds parameter DEADBAND; results below it are output as 0.
module adc_chan_averager #(
    parameter int unsigned NCH      = 4,
    parameter int unsigned DATA_W   = 12,
    parameter int unsigned AVG_LOG2 = 4,
    parameter int unsigned ADDR_W   = 7,
    parameter int unsigned TIMEOUT  = 255
`ifdef ADC_AVG_DEADBAND_EN
    ,
    parameter int unsigned DEADBAND = 16
`endif
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NCH-1:0]        ch_en,
    input  logic [NCH*ADDR_W-1:0] chan_addr,
    input  logic                  eoc,
    adc_chan_averager_if.master   bus,
    output logic                  timeout_err,
    output logic [7:0]            overrun_cnt
);
    localparam int unsigned AccW  = DATA_W + AVG_LOG2;
    localparam int unsigned RndW  = AccW + 1;
    localparam int unsigned CntW  = AVG_LOG2 + 1;
    localparam int unsigned CurW  = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int unsigned TmrW  = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    localparam int unsigned NSamp = 2 ** AVG_LOG2;
    localparam int unsigned Half  = NSamp / 2;

    typedef enum logic [2:0] {StIdle, StReq, StWait, StOut, StNext} state_e;

    state_e            state_q, state_d;
    logic [CurW-1:0]   cur_q, cur_d, cur_nxt;
    logic [AccW-1:0]   acc_q [NCH];
    logic [AccW-1:0]   acc_d [NCH];
    logic [CntW-1:0]   cnt_q [NCH];
    logic [CntW-1:0]   cnt_d [NCH];
    logic [TmrW-1:0]   tmr_q, tmr_d;
    logic [2:0]        avg_chan_q, avg_chan_d;
    logic [DATA_W-1:0] avg_data_q, avg_data_d;
    logic [7:0]        overrun_q, overrun_d;

    logic [DATA_W-1:0] sample;
    logic [AccW-1:0]   acc_sum;
    logic [RndW-1:0]   rnd;
    logic [DATA_W-1:0] result;
    logic              last_sample;
    logic              tmr_expired;
    logic              unused_do_in;

    assign sample       = bus.do_in[15 -: DATA_W];
    assign acc_sum      = acc_q[cur_q] + AccW'(sample);
    // Round half up; Half is 0 when AVG_LOG2 = 0 so the sample passes through exactly.
    assign rnd          = (RndW'(acc_sum) + RndW'(Half)) >> AVG_LOG2;
    assign last_sample  = (cnt_q[cur_q] == CntW'(NSamp - 1));
    assign tmr_expired  = (tmr_q == TmrW'(TIMEOUT - 1));
    assign unused_do_in = ^bus.do_in;

`ifdef ADC_AVG_DEADBAND_EN
    assign result = (DATA_W'(rnd) < DATA_W'(DEADBAND)) ? '0 : DATA_W'(rnd);
`else
    assign result = DATA_W'(rnd);
`endif

    // Nearest enabled channel above cur with wrap; unchanged if no other channel is enabled.
    always_comb begin
        cur_nxt = cur_q;
        for (int k = NCH - 1; k >= 1; k--) begin
            if (ch_en[CurW'((int'(cur_q) + k) % NCH)]) begin
                cur_nxt = CurW'((int'(cur_q) + k) % NCH);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle: begin
                if (eoc && (|ch_en)) begin
                    state_d = ch_en[cur_q] ? StReq : StNext;
                end
            end
            StReq:  state_d = StWait;
            StWait: begin
                if (bus.drdy) begin
                    state_d = last_sample ? StOut : StNext;
                end else if (tmr_expired) begin
                    state_d = StNext;
                end
            end
            StOut:  if (bus.avg_ready) state_d = StNext;
            StNext: state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        bus.den       = (state_q == StReq);
        bus.daddr     = (state_q == StReq) ? chan_addr[cur_q*ADDR_W +: ADDR_W] : '0;
        bus.avg_valid = (state_q == StOut);
        bus.avg_chan  = avg_chan_q;
        bus.avg_data  = avg_data_q;
        timeout_err   = (state_q == StWait) && !bus.drdy && tmr_expired;
        overrun_cnt   = overrun_q;
    end

    always_comb begin
        cur_d      = cur_q;
        acc_d      = acc_q;
        cnt_d      = cnt_q;
        tmr_d      = tmr_q;
        avg_chan_d = avg_chan_q;
        avg_data_d = avg_data_q;
        overrun_d  = overrun_q;
        case (state_q)
            StReq: tmr_d = '0;
            StWait: begin
                if (bus.drdy) begin
                    acc_d[cur_q] = acc_sum;
                    cnt_d[cur_q] = cnt_q[cur_q] + 1'b1;
                    if (last_sample) begin
                        avg_chan_d = 3'(cur_q);
                        avg_data_d = result;
                    end
                end else begin
                    tmr_d = tmr_q + 1'b1;
                end
            end
            StOut: begin
                if (bus.avg_ready) begin
                    acc_d[cur_q] = '0;
                    cnt_d[cur_q] = '0;
                end
            end
            StNext: cur_d = cur_nxt;
            default: ;
        endcase
        if (eoc && (state_q != StIdle) && (overrun_q != 8'hFF)) begin
            overrun_d = overrun_q + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cur_q      <= '0;
            tmr_q      <= '0;
            avg_chan_q <= '0;
            avg_data_q <= '0;
            overrun_q  <= '0;
            for (int i = 0; i < NCH; i++) begin
                acc_q[i] <= '0;
                cnt_q[i] <= '0;
            end
        end else begin
            cur_q      <= cur_d;
            tmr_q      <= tmr_d;
            avg_chan_q <= avg_chan_d;
            avg_data_q <= avg_data_d;
            overrun_q  <= overrun_d;
            acc_q      <= acc_d;
            cnt_q      <= cnt_d;
        end
    end
endmodule

// File: tb/tb_adc_chan_averager.sv
// Scoreboard bench for adc_chan_averager: stimulus queues expected DRP addresses and
// results, a negedge monitor pops and compares them.
module tb_adc_chan_averager;
    localparam int unsigned NCH      = 4;
    localparam int unsigned DATA_W   = 12;
    localparam int unsigned AVG_LOG2 = 1;
    localparam int unsigned ADDR_W   = 7;
    localparam int unsigned TIMEOUT  = 20;
`ifdef ADC_AVG_DEADBAND_EN
    localparam logic [11:0] ExpLow = 12'h000;
`else
    localparam logic [11:0] ExpLow = 12'h00F;
`endif

    logic                  clk = 1'b0;
    logic                  rst;
    logic [NCH-1:0]        ch_en;
    logic [NCH*ADDR_W-1:0] chan_addr;
    logic                  eoc;
    logic                  timeout_err;
    logic [7:0]            overrun_cnt;

    logic [14:0] res_q[$];
    logic [6:0]  addr_q[$];
    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    adc_chan_averager_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

    adc_chan_averager #(
        .NCH(NCH), .DATA_W(DATA_W), .AVG_LOG2(AVG_LOG2), .ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk),
        .rst(rst),
        .ch_en(ch_en),
        .chan_addr(chan_addr),
        .eoc(eoc),
        .bus(bus),
        .timeout_err(timeout_err),
        .overrun_cnt(overrun_cnt)
    );

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One conversion on channel ch; the result is expected on the second visit.
    task automatic conv(input int ch, input logic [15:0] d, input bit has_out,
                        input logic [11:0] exp);
        addr_q.push_back(7'(16 + ch));
        eoc = 1'b1;
        tick();
        eoc = 1'b0;
        tick();
        bus.drdy  = 1'b1;
        bus.do_in = d;
        if (has_out) res_q.push_back({3'(ch), exp});
        tick();
        bus.drdy  = 1'b0;
        bus.do_in = '0;
        if (has_out) chk("latency_valid", int'(bus.avg_valid), 1);
        repeat (3) tick();
    endtask

    initial begin : monitor
        logic [14:0] r;
        logic [6:0]  a;
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (bus.avg_valid && bus.avg_ready) begin
                    if (res_q.size() == 0) begin
                        n_cmp++;
                        n_err++;
                        $display("FAIL res_unexpected: chan %0d data %0h, none expected",
                                 bus.avg_chan, bus.avg_data);
                    end else begin
                        r = res_q.pop_front();
                        chk("res_chan", int'(bus.avg_chan), int'(r[14:12]));
                        chk("res_data", int'(bus.avg_data), int'(r[11:0]));
                    end
                end
                if (bus.den) begin
                    if (addr_q.size() == 0) begin
                        n_cmp++;
                        n_err++;
                        $display("FAIL den_unexpected: daddr %0h, none expected", bus.daddr);
                    end else begin
                        a = addr_q.pop_front();
                        chk("daddr", int'(bus.daddr), int'(a));
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int tcyc;
        int bad;
        int dens;
        rst       = 1'b1;
        eoc       = 1'b0;
        ch_en     = 4'b1001;
        chan_addr = {7'h13, 7'h12, 7'h11, 7'h10};
        bus.drdy      = 1'b0;
        bus.do_in     = '0;
        bus.avg_ready = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        chk("rst_ctrl", int'({bus.den, bus.avg_valid, timeout_err}), 0);
        chk("rst_daddr", int'(bus.daddr), 0);
        chk("rst_result", int'({bus.avg_chan, bus.avg_data}), 0);
        chk("rst_overrun", int'(overrun_cnt), 0);

        // Two channels alternate, mid-scale sample
        for (int i = 0; i < 16; i++) begin
            conv((i % 2) ? 3 : 0, 16'h8000, ((i / 2) % 2) == 1, 12'h800);
        end
        chk("overrun_idle", int'(overrun_cnt), 0);

        // Single channel: rounding, full scale, deadband region
        ch_en = 4'b0001;
        conv(0, 16'h0010, 0, 12'h0);
        conv(0, 16'h0020, 1, 12'h002);
        conv(0, 16'hFFF0, 0, 12'h0);
        conv(0, 16'hFFF0, 1, 12'hFFF);
        conv(0, 16'h00F0, 0, 12'h0);
        conv(0, 16'h00F0, 1, ExpLow);
        conv(0, 16'h0100, 0, 12'h0);
        conv(0, 16'h0100, 1, 12'h010);

        // Back-pressure with eoc overruns
        bus.avg_ready = 1'b0;
        conv(0, 16'h1230, 0, 12'h0);
        conv(0, 16'h1250, 1, 12'h124);
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            eoc = (i < 6) && (i % 2 == 0);
            tick();
            if (!(bus.avg_valid && bus.avg_data == 12'h124 && bus.avg_chan == 3'd0)) bad++;
        end
        eoc = 1'b0;
        chk("hold_stable", bad, 0);
        chk("overrun_3", int'(overrun_cnt), 3);
        for (int i = 0; i < 257; i++) begin
            eoc = 1'b1;
            tick();
            eoc = 1'b0;
            tick();
        end
        chk("overrun_sat", int'(overrun_cnt), 255);
        chk("hold_valid", int'(bus.avg_valid), 1);
        bus.avg_ready = 1'b1;
        repeat (3) tick();
        chk("accept_once", int'(bus.avg_valid), 0);

        // DRP timeout on ch0, then sequencing resumes on ch3
        ch_en = 4'b1001;
        addr_q.push_back(7'h10);
        eoc = 1'b1;
        tick();
        eoc = 1'b0;
        tcyc = -1;
        for (int k = 1; k <= int'(TIMEOUT) + 5; k++) begin
            tick();
            if (timeout_err) begin
                tcyc = k;
                break;
            end
        end
        chk("timeout_latency", tcyc, int'(TIMEOUT));
        tick();
        chk("timeout_pulse", int'(timeout_err), 0);
        repeat (3) tick();
        bus.drdy  = 1'b1;
        bus.do_in = 16'hFFF0;
        tick();
        bus.drdy  = 1'b0;
        bus.do_in = '0;
        tick();
        conv(3, 16'h0300, 0, 12'h0);
        conv(0, 16'h0100, 0, 12'h0);
        conv(3, 16'h0500, 1, 12'h040);
        conv(0, 16'h0300, 1, 12'h020);

        // ch3 disabled mid-transaction: capture completes, partial sum kept
        addr_q.push_back(7'h13);
        eoc = 1'b1;
        tick();
        eoc   = 1'b0;
        ch_en = 4'b0001;
        tick();
        bus.drdy  = 1'b1;
        bus.do_in = 16'h0100;
        tick();
        bus.drdy  = 1'b0;
        bus.do_in = '0;
        repeat (3) tick();
        conv(0, 16'h0700, 0, 12'h0);
        ch_en = 4'b1001;
        conv(0, 16'h0900, 1, 12'h080);
        conv(3, 16'h0300, 1, 12'h020);

        // eoc with current channel disabled moves on without a DRP read
        ch_en = 4'b1000;
        eoc = 1'b1;
        tick();
        eoc = 1'b0;
        repeat (3) tick();
        conv(3, 16'h0500, 0, 12'h0);
        conv(3, 16'h0700, 1, 12'h060);

        // Reset in WAIT, stray drdy afterwards
        addr_q.push_back(7'h13);
        eoc = 1'b1;
        tick();
        eoc = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        rst       = 1'b0;
        bus.drdy  = 1'b1;
        bus.do_in = 16'hFF00;
        tick();
        bus.drdy  = 1'b0;
        bus.do_in = '0;
        chk("wrst_ctrl", int'({bus.den, bus.avg_valid, timeout_err}), 0);
        chk("wrst_daddr", int'(bus.daddr), 0);
        chk("wrst_result", int'({bus.avg_chan, bus.avg_data}), 0);
        chk("wrst_overrun", int'(overrun_cnt), 0);
        ch_en = 4'b1001;
        conv(0, 16'h0200, 0, 12'h0);
        conv(3, 16'h0200, 0, 12'h0);
        conv(0, 16'h0400, 1, 12'h030);
        conv(3, 16'h0400, 1, 12'h030);

        // No channels enabled: eoc never produces den
        ch_en = 4'b0000;
        dens = 0;
        for (int i = 0; i < 5; i++) begin
            eoc = 1'b1;
            tick();
            if (bus.den) dens++;
            eoc = 1'b0;
            tick();
            if (bus.den) dens++;
        end
        chk("no_den", dens, 0);
        chk("no_den_overrun", int'(overrun_cnt), 0);

        repeat (5) tick();
        chk("res_left", res_q.size(), 0);
        chk("addr_left", addr_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
